// File: rtl/branch_predictor_pkg.sv
// Shared branch-prediction definitions used by fetch, execute and the predictor.
// Holds the fetch-bus layout, PHT counter encodings and default table geometry.
package branch_predictor_pkg;

  localparam int BP_BUS_W          = 37;
  localparam int BP_PC_W           = 32;
  localparam int BP_STATE_W        = 2;
  localparam int PHT_IDX_W_DEFAULT = 8;
  localparam int BTB_IDX_W_DEFAULT = 5;

  typedef enum logic [BP_STATE_W-1:0] {
    PHT_SNT = 2'b00,
    PHT_WNT = 2'b01,
    PHT_WT  = 2'b10,
    PHT_ST  = 2'b11
  } pht_state_e;

  typedef struct packed {
    logic                  predict_valid;
    logic                  predict_taken;
    logic [BP_STATE_W-1:0] predict_state;
    logic                  btb_hit;
    logic [BP_PC_W-1:0]    predict_target;
  } bp_bus_t;

  function automatic pht_state_e pht_next(input pht_state_e cur, input logic taken);
    pht_state_e nxt;
    nxt = cur;
    if (taken) begin
      if (cur != PHT_ST) nxt = pht_state_e'(cur + 2'd1);
    end else begin
      if (cur != PHT_SNT) nxt = pht_state_e'(cur - 2'd1);
    end
    return nxt;
  endfunction

  function automatic logic [31:0] sat_inc(input logic [31:0] v);
    return (v == 32'hFFFF_FFFF) ? v : v + 32'd1;
  endfunction

endpackage

// File: rtl/bp_btb.sv
// Branch target buffer: direct-mapped valid/tag/target array, async read, sync write.
// Zero-cycle read latency; write visible next cycle; no backpressure.
module bp_btb
  import branch_predictor_pkg::*;
#(
  parameter int IDX_W = BTB_IDX_W_DEFAULT,
  parameter int TAG_W = BP_PC_W - BTB_IDX_W_DEFAULT - 2
) (
  input  logic               clk,
  input  logic               resetn,
  input  logic [IDX_W-1:0]   rd_idx,
  input  logic [TAG_W-1:0]   rd_tag,
  output logic               rd_hit,
  output logic [BP_PC_W-1:0] rd_target,
  input  logic               wr_en,
  input  logic [IDX_W-1:0]   wr_idx,
  input  logic [TAG_W-1:0]   wr_tag,
  input  logic [BP_PC_W-1:0] wr_target
);

  localparam int ENTRIES = 1 << IDX_W;

  logic               valid_q  [ENTRIES];
  logic [TAG_W-1:0]   tag_q    [ENTRIES];
  logic [BP_PC_W-1:0] target_q [ENTRIES];

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      for (int i = 0; i < ENTRIES; i++) begin
        valid_q[i]  <= 1'b0;
        tag_q[i]    <= '0;
        target_q[i] <= '0;
      end
    end else if (wr_en) begin
      // Direct-mapped: a new taken branch simply evicts whatever aliased here.
      valid_q[wr_idx]  <= 1'b1;
      tag_q[wr_idx]    <= wr_tag;
      target_q[wr_idx] <= wr_target;
    end
  end

  assign rd_hit    = valid_q[rd_idx] && (tag_q[rd_idx] == rd_tag);
  assign rd_target = target_q[rd_idx];

endmodule

// File: rtl/branch_predictor.sv
// Bimodal predictor (2-bit PHT) plus BTB; combinational lookup for fetch, updates from execute.
// Zero-cycle lookup, one-cycle update visibility; no backpressure (one update per cycle).
module branch_predictor
  import branch_predictor_pkg::*;
#(
  parameter int PHT_IDX_W = PHT_IDX_W_DEFAULT,
  parameter int BTB_IDX_W = BTB_IDX_W_DEFAULT
) (
  input  logic                clk,
  input  logic                resetn,
  input  logic [BP_PC_W-1:0]  bp_pc_i,
  output logic [BP_BUS_W-1:0] bp_to_if_bus,
  input  logic                upd_valid,
  input  logic [BP_PC_W-1:0]  upd_pc,
  input  logic                upd_taken,
  input  logic [BP_PC_W-1:0]  upd_target,
  input  logic                upd_mispredict,
  output logic [31:0]         stat_branch_cnt,
  output logic [31:0]         stat_mispred_cnt
);

  localparam int PHT_ENTRIES = 1 << PHT_IDX_W;
  localparam int BTB_TAG_W   = BP_PC_W - BTB_IDX_W - 2;

  pht_state_e        pht_q [PHT_ENTRIES];
  logic              warm_q;
  logic [31:0]       stat_branch_q;
  logic [31:0]       stat_mispred_q;

  logic [PHT_IDX_W-1:0] lk_pht_idx;
  logic [PHT_IDX_W-1:0] upd_pht_idx;
  logic [1:0]           lk_state;
  logic                 btb_hit;
  logic [BP_PC_W-1:0]   btb_target;
  bp_bus_t              bus;
  logic                 unused_pc_bits;

  assign lk_pht_idx  = bp_pc_i[PHT_IDX_W+1:2];
  assign upd_pht_idx = upd_pc[PHT_IDX_W+1:2];
  assign unused_pc_bits = &{1'b0, bp_pc_i[1:0], upd_pc[1:0]};

  bp_btb #(
    .IDX_W (BTB_IDX_W),
    .TAG_W (BTB_TAG_W)
  ) u_btb (
    .clk       (clk),
    .resetn    (resetn),
    .rd_idx    (bp_pc_i[BTB_IDX_W+1:2]),
    .rd_tag    (bp_pc_i[BP_PC_W-1:BTB_IDX_W+2]),
    .rd_hit    (btb_hit),
    .rd_target (btb_target),
    .wr_en     (upd_valid && upd_taken),
    .wr_idx    (upd_pc[BTB_IDX_W+1:2]),
    .wr_tag    (upd_pc[BP_PC_W-1:BTB_IDX_W+2]),
    .wr_target (upd_target)
  );

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      for (int i = 0; i < PHT_ENTRIES; i++) pht_q[i] <= PHT_WNT;
    end else if (upd_valid) begin
      pht_q[upd_pht_idx] <= pht_next(pht_q[upd_pht_idx], upd_taken);
    end
  end

  // Fetch must not trust the tables until one clean cycle out of reset.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) warm_q <= 1'b0;
    else         warm_q <= 1'b1;
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      stat_branch_q  <= '0;
      stat_mispred_q <= '0;
    end else if (upd_valid) begin
      stat_branch_q <= sat_inc(stat_branch_q);
      if (upd_mispredict) stat_mispred_q <= sat_inc(stat_mispred_q);
    end
  end

  assign lk_state = pht_q[lk_pht_idx];

  always_comb begin
    bus                = '0;
    bus.predict_valid  = warm_q;
    bus.predict_state  = lk_state;
    bus.predict_taken  = lk_state[1];
    bus.btb_hit        = btb_hit;
    bus.predict_target = btb_hit ? btb_target : bp_pc_i + 32'd4;
  end

  assign bp_to_if_bus     = bus;
  assign stat_branch_cnt  = stat_branch_q;
  assign stat_mispred_cnt = stat_mispred_q;

endmodule
